pc_sequencer: RTL and testbench

- Program-counter controller for the RISC fetch path.
- Owns the PC register and sequences the shared ripple half-adder incrementor (PC+1) against branch redirects, halt requests and a valid/ready fetch handshake.
- Sits between the branch/decode stage, which supplies redirects, and the instruction memory interface, which consumes PC.

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter controller for the fetch path: owns PC, sequences the
// half-adder incrementor against branch redirects, halt requests and fetch handshake.
module pc_sequencer #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             HALT_REQ,
    input  logic             BR_VALID,
    input  logic [WIDTH-1:0] BR_TARGET,
    input  logic             FETCH_READY,
    output logic             FETCH_VALID,
    output logic [WIDTH-1:0] PC,
    output logic             WRAP,
    output logic             HALTED,
    output logic [CNT_W-1:0] FETCH_CNT,
    output logic [1:0]       DBG_STATE
);

    // Handshake: a fetch is accepted in any cycle where FETCH_VALID and
    // FETCH_READY are both high; while VALID is high and READY low the offered
    // PC is held, except that BR_VALID flushes the offer and redirects PC.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam int NSTG = WIDTH / 4;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             halted_q, halted_d;
    logic             wrap_q, wrap_d;
    logic             accept;

    logic [NSTG:0]    stg_carry;
    logic [WIDTH-1:0] pc_inc;

    // Chain of 4-bit half-adder incrementors with a constant carry-in of 1.
    assign stg_carry[0] = 1'b1;

    for (genvar g = 0; g < NSTG; g++) begin : g_inc
        logic [4:0] c;
        assign c[0] = stg_carry[g];
        for (genvar b = 0; b < 4; b++) begin : g_ha
            assign pc_inc[4*g+b] = pc_q[4*g+b] ^ c[b];
            assign c[b+1]        = pc_q[4*g+b] & c[b];
        end
        assign stg_carry[g+1] = c[4];
    end

    assign accept = fetch_valid_q & FETCH_READY;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (BR_VALID) pc_d = BR_TARGET;
                if (START)    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (BR_VALID) begin
                    pc_d = BR_TARGET;
                end else if (accept) begin
                    pc_d   = pc_inc;
                    wrap_d = stg_carry[NSTG];
                end
                if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
                if (HALT_REQ) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (BR_VALID)             pc_d = BR_TARGET;
                if (START && !HALT_REQ)   state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        fetch_valid_d = (state_d == ST_FETCH);
        halted_d      = (state_d == ST_HALT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            wrap_q        <= wrap_d;
        end
    end

    assign FETCH_VALID = fetch_valid_q;
    assign PC          = pc_q;
    assign WRAP        = wrap_q;
    assign HALTED      = halted_q;
    assign FETCH_CNT   = cnt_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default instance plus a CNT_W=2 instance
// driven by the same stimulus to observe counter saturation.
module tb_pc_sequencer;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       HALT_REQ;
    logic       BR_VALID;
    logic [3:0] BR_TARGET;
    logic       FETCH_READY;

    logic       fetch_valid, wrap, halted;
    logic [3:0] pc;
    logic [7:0] fetch_cnt;
    logic [1:0] dbg_state;

    logic       s_fetch_valid, s_wrap, s_halted;
    logic [3:0] s_pc;
    logic [1:0] s_fetch_cnt;
    logic [1:0] s_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    pc_sequencer #(.WIDTH(4), .RESET_VECTOR(4'd0), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .HALT_REQ(HALT_REQ),
        .BR_VALID(BR_VALID), .BR_TARGET(BR_TARGET), .FETCH_READY(FETCH_READY),
        .FETCH_VALID(fetch_valid), .PC(pc), .WRAP(wrap), .HALTED(halted),
        .FETCH_CNT(fetch_cnt), .DBG_STATE(dbg_state)
    );

    pc_sequencer #(.WIDTH(4), .RESET_VECTOR(4'd0), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .START(START), .HALT_REQ(HALT_REQ),
        .BR_VALID(BR_VALID), .BR_TARGET(BR_TARGET), .FETCH_READY(FETCH_READY),
        .FETCH_VALID(s_fetch_valid), .PC(s_pc), .WRAP(s_wrap), .HALTED(s_halted),
        .FETCH_CNT(s_fetch_cnt), .DBG_STATE(s_dbg_state)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver: advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [3:0] e_pc, input logic e_fv,
                            input logic e_halt, input logic e_wrap, input logic [7:0] e_cnt);
        chk({tag, ".pc"},     32'(pc),          32'(e_pc));
        chk({tag, ".fvalid"}, 32'(fetch_valid), 32'(e_fv));
        chk({tag, ".halted"}, 32'(halted),      32'(e_halt));
        chk({tag, ".wrap"},   32'(wrap),        32'(e_wrap));
        chk({tag, ".cnt"},    32'(fetch_cnt),   32'(e_cnt));
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; HALT_REQ = 1'b0; BR_VALID = 1'b0;
        BR_TARGET = 4'd0; FETCH_READY = 1'b0;
        #12;
        chk_main("reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset.state", 32'(dbg_state), 32'(S_IDLE));
        chk("reset.sat_cnt", 32'(s_fetch_cnt), 32'd0);
        RST = 1'b0;

        // Start with READY held high
        START = 1'b1; FETCH_READY = 1'b1;
        tick(); START = 1'b0;
        chk_main("start", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("start.state", 32'(dbg_state), 32'(S_FETCH));
        tick(); chk_main("seq1", 4'd1, 1'b1, 1'b0, 1'b0, 8'd1);
        tick(); chk_main("seq2", 4'd2, 1'b1, 1'b0, 1'b0, 8'd2);
        tick(); chk_main("seq3", 4'd3, 1'b1, 1'b0, 1'b0, 8'd3);
        chk("seq3.sat_cnt", 32'(s_fetch_cnt), 32'd3);
        tick(); chk_main("seq4", 4'd4, 1'b1, 1'b0, 1'b0, 8'd4);
        tick(); chk_main("seq5", 4'd5, 1'b1, 1'b0, 1'b0, 8'd5);
        chk("sat5.sat_cnt", 32'(s_fetch_cnt), 32'd3);

        // Backpressure at PC=5
        FETCH_READY = 1'b0;
        tick(); chk_main("stall1", 4'd5, 1'b1, 1'b0, 1'b0, 8'd5);
        tick(); chk_main("stall2", 4'd5, 1'b1, 1'b0, 1'b0, 8'd5);
        tick(); chk_main("stall3", 4'd5, 1'b1, 1'b0, 1'b0, 8'd5);
        FETCH_READY = 1'b1;
        tick(); chk_main("unstall", 4'd6, 1'b1, 1'b0, 1'b0, 8'd6);
        tick(); chk_main("pc7", 4'd7, 1'b1, 1'b0, 1'b0, 8'd7);

        // Branch with accept at PC=7, then branch during a stall
        BR_VALID = 1'b1; BR_TARGET = 4'd2;
        tick(); chk_main("br_acc", 4'd2, 1'b1, 1'b0, 1'b0, 8'd8);
        FETCH_READY = 1'b0; BR_TARGET = 4'd12;
        tick(); chk_main("br_stall", 4'd12, 1'b1, 1'b0, 1'b0, 8'd8);

        // Wrap-around
        BR_TARGET = 4'd15;
        tick(); chk_main("br15", 4'd15, 1'b1, 1'b0, 1'b0, 8'd8);
        BR_VALID = 1'b0; FETCH_READY = 1'b1;
        tick(); chk_main("wrap", 4'd0, 1'b1, 1'b0, 1'b1, 8'd9);
        FETCH_READY = 1'b0;
        tick(); chk_main("wrap_clr", 4'd0, 1'b1, 1'b0, 1'b0, 8'd9);
        BR_VALID = 1'b1; BR_TARGET = 4'd15;
        tick(); chk_main("br15b", 4'd15, 1'b1, 1'b0, 1'b0, 8'd9);
        BR_TARGET = 4'd0; FETCH_READY = 1'b1;
        tick(); chk_main("br0_acc15", 4'd0, 1'b1, 1'b0, 1'b0, 8'd10);
        BR_TARGET = 4'd9; FETCH_READY = 1'b0;
        tick(); chk_main("br9", 4'd9, 1'b1, 1'b0, 1'b0, 8'd10);
        BR_VALID = 1'b0;

        // Halt with accept, branch while halted, resume
        HALT_REQ = 1'b1; FETCH_READY = 1'b1;
        tick(); chk_main("halt_acc", 4'd10, 1'b0, 1'b1, 1'b0, 8'd11);
        chk("halt.state", 32'(dbg_state), 32'(S_HALT));
        HALT_REQ = 1'b0;
        tick(); chk_main("halt_hold", 4'd10, 1'b0, 1'b1, 1'b0, 8'd11);
        BR_VALID = 1'b1; BR_TARGET = 4'd4;
        tick(); chk_main("halt_br", 4'd4, 1'b0, 1'b1, 1'b0, 8'd11);
        BR_VALID = 1'b0; START = 1'b1; HALT_REQ = 1'b1;
        tick(); chk_main("halt_both", 4'd4, 1'b0, 1'b1, 1'b0, 8'd11);
        HALT_REQ = 1'b0;
        tick(); chk_main("resume", 4'd4, 1'b1, 1'b0, 1'b0, 8'd11);
        START = 1'b0;
        tick(); chk_main("resume_acc", 4'd5, 1'b1, 1'b0, 1'b0, 8'd12);

        // Asynchronous reset between edges
        FETCH_READY = 1'b0; BR_VALID = 1'b1; BR_TARGET = 4'd11;
        tick(); chk_main("br11", 4'd11, 1'b1, 1'b0, 1'b0, 8'd12);
        BR_VALID = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk_main("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("async_rst.sat_cnt", 32'(s_fetch_cnt), 32'd0);
        tick(); RST = 1'b0;

        // IDLE: branch loads PC, HALT_REQ ignored; branch together with START
        BR_VALID = 1'b1; BR_TARGET = 4'd6; HALT_REQ = 1'b1;
        tick(); chk_main("idle_br", 4'd6, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("idle_br.state", 32'(dbg_state), 32'(S_IDLE));
        HALT_REQ = 1'b0; BR_TARGET = 4'd3; START = 1'b1;
        tick(); chk_main("idle_br_start", 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        BR_VALID = 1'b0; START = 1'b0; HALT_REQ = 1'b1;
        tick(); chk_main("halt_noacc", 4'd3, 1'b0, 1'b1, 1'b0, 8'd0);
        HALT_REQ = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
